phase_sequencer: RTL and testbench
==================================

# phase_sequencer

Multi-cycle phase controller for the RockWave core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and drives the per-stage `phase_*` enables that gate each stage's output flip-flops (for example `phase_decode` into instruction_decode). It holds a phase while that stage raises its `stall_*`. It also keeps retired-instruction and stall-cycle counters and flags a stuck stage with a watchdog.

## Interface
Parameters:
- `STALL_LIMIT`, default 255: consecutive stall cycles in one phase that set `stall_timeout`; legal range 1..65535.
- `CNT_W`, default 32: width of `retire_count` and `stall_count`.

Ports:
- `clk`  in  1: CPU clock; single clock domain.
- `rst_n`  in  1: reset, synchronous, active-low.
- `run`  in  1: 1 = fetch and execute instructions; 0 = stop at the next instruction boundary.
- `stall_fetch`, `stall_decode`, `stall_execute`, `stall_memory`, `stall_writeback`  in  1 each: the stage asks to stay in its phase.
- `cnt_clr`  in  1: synchronous clear of both counters and `stall_timeout`.
- `phase_fetch`, `phase_decode`, `phase_execute`, `phase_memory`, `phase_writeback`  out  1 each: one-hot stage enables.
- `busy`  out  1: the FSM is not in IDLE.
- `retire`  out  1: the current cycle completes WRITEBACK.
- `retire_count`  out  CNT_W: number of retired instructions.
- `stall_count`  out  CNT_W: total stalled cycles.
- `stall_timeout`  out  1: sticky watchdog flag.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK. The state is registered.
- `phase_X` = (state == X), decoded directly from the state register. At most one `phase_*` is high. All are 0 in IDLE.
- Transitions:
  - IDLE → FETCH when `run` = 1.
  - FETCH → DECODE → EXECUTE → MEMORY → WRITEBACK: each advance happens when the current phase's stall = 0. Otherwise the state holds.
  - WRITEBACK with `stall_writeback` = 0 → FETCH if `run` = 1, else IDLE.
- `run` is sampled only in IDLE and on WRITEBACK exit. Dropping `run` mid-instruction always lets the instruction finish.
- Only the current phase's stall input matters. Stall inputs are ignored in IDLE and for every non-current phase.
- `retire` = `phase_writeback` & ~`stall_writeback` (combinational).
- `retire_count` increments by 1 on each cycle with `retire` = 1. It wraps modulo 2^CNT_W.
- `stall_count` increments on every cycle in which the current phase's stall = 1. It wraps.
- Watchdog counter `stall_run`, width clog2(STALL_LIMIT+1):
  - Increments while the current phase's stall = 1 and saturates at STALL_LIMIT.
  - Clears to 0 on any phase advance and in IDLE.
  - On the edge where it reaches STALL_LIMIT, `stall_timeout` is set.
  - `stall_timeout` stays set until `cnt_clr` or reset. The FSM keeps waiting; it does not abort.
- `cnt_clr` wins over a simultaneous increment or set. It does not clear `stall_run` and does not affect the FSM.
- `busy` = (state != IDLE).

## Timing
- Reset values, applied at a clock edge with `rst_n` = 0:
  - state = IDLE.
  - All `phase_*` = 0, `busy` = 0, `retire` = 0.
  - Both counters = 0, `stall_timeout` = 0, `stall_run` = 0.
- Reset mid-instruction aborts that instruction immediately. It is not counted as retired.
- `run` goes to 1 in cycle n while in IDLE → `phase_fetch` = 1 in cycle n+1.
- An unstalled instruction occupies exactly 5 cycles, one per phase. Back-to-back instructions have no IDLE gap: WRITEBACK is followed directly by FETCH.
- Each stall cycle adds exactly 1 cycle to its phase.
- Counter updates are visible in the cycle after the event:
  - `retire` in cycle n → `retire_count` updated in cycle n+1.
  - A stall that reaches STALL_LIMIT consecutive cycles ending in cycle n → `stall_timeout` = 1 in cycle n+1.

## Test plan
- Reset, then `run` = 1 held, no stalls, 3 instructions: phases cycle F,D,E,M,W ×3 back-to-back; `retire` pulses in cycles 5, 10 and 15 after the first FETCH; `retire_count` = 3 and `stall_count` = 0.
- `stall_decode` = 1 for 4 cycles during DECODE, `stall_memory` = 1 asserted during FETCH: DECODE lasts 5 cycles; FETCH is unaffected; `stall_count` = 4; total instruction time is 9 cycles.
- `run` dropped to 0 during EXECUTE: MEMORY and WRITEBACK still complete; the FSM enters IDLE; `busy` = 0; `retire_count` increments by 1.
- STALL_LIMIT = 4, `stall_execute` held high for 6 cycles: `stall_timeout` = 1 starting the cycle after the 4th stall cycle; `stall_count` = 6; the FSM then advances normally. Pulsing `cnt_clr` clears the flag and both counters.
- `rst_n` = 0 for one edge while in MEMORY: the next cycle shows IDLE with all outputs 0. With `run` = 1, FETCH follows one cycle later.
- `retire_count` preloaded near the top via force to 2^CNT_W − 1, plus one retire: the count wraps to 0. `cnt_clr` asserted in the same cycle as `retire`: the count reads 0.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: five-phase instruction stepper with per-stage holds,
// retire/stall counters and a sticky stuck-stage watchdog.
module phase_sequencer #(
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             stall_fetch,
  input  logic             stall_decode,
  input  logic             stall_execute,
  input  logic             stall_memory,
  input  logic             stall_writeback,
  input  logic             cnt_clr,
  output logic             phase_fetch,
  output logic             phase_decode,
  output logic             phase_execute,
  output logic             phase_memory,
  output logic             phase_writeback,
  output logic             busy,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout
);

  localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(STALL_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK
  } state_e;

  state_e           state_q;
  logic [RUN_W-1:0] stall_run_q;
  logic [CNT_W-1:0] retire_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_q;
  logic             stall_cur;

  assign phase_fetch     = (state_q == FETCH);
  assign phase_decode    = (state_q == DECODE);
  assign phase_execute   = (state_q == EXECUTE);
  assign phase_memory    = (state_q == MEMORY);
  assign phase_writeback = (state_q == WRITEBACK);
  assign busy            = (state_q != IDLE);
  assign retire          = phase_writeback & ~stall_writeback;

  assign retire_count  = retire_cnt_q;
  assign stall_count   = stall_cnt_q;
  assign stall_timeout = timeout_q;

  // Only the stall of the phase we are in is ever looked at.
  always_comb begin
    stall_cur = 1'b0;
    unique case (1'b1)
      phase_fetch:     stall_cur = stall_fetch;
      phase_decode:    stall_cur = stall_decode;
      phase_execute:   stall_cur = stall_execute;
      phase_memory:    stall_cur = stall_memory;
      phase_writeback: stall_cur = stall_writeback;
      default:         stall_cur = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stall_run_q  <= '0;
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:      if (run) state_q <= FETCH;
        FETCH:     if (!stall_fetch) state_q <= DECODE;
        DECODE:    if (!stall_decode) state_q <= EXECUTE;
        EXECUTE:   if (!stall_execute) state_q <= MEMORY;
        MEMORY:    if (!stall_memory) state_q <= WRITEBACK;
        WRITEBACK: if (!stall_writeback)
                     state_q <= run ? FETCH : IDLE;
        default:   state_q <= IDLE;
      endcase

      if (!stall_cur) begin
        stall_run_q <= '0;
      end else if (stall_run_q != RUN_MAX) begin
        stall_run_q <= stall_run_q + 1'b1;
      end

      // Clear beats any same-cycle increment or watchdog set.
      if (cnt_clr) begin
        retire_cnt_q <= '0;
        stall_cnt_q  <= '0;
        timeout_q    <= 1'b0;
      end else begin
        if (retire) retire_cnt_q <= retire_cnt_q + 1'b1;
        if (stall_cur) stall_cnt_q <= stall_cnt_q + 1'b1;
        if (stall_cur && stall_run_q == RUN_HIT)
          timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (STALL_LIMIT = 4, CNT_W = 32)
// with hand-computed phase, retire and counter expectations.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, cnt_clr;
  logic        s_f, s_d, s_e, s_m, s_w;
  logic        p_f, p_d, p_e, p_m, p_w;
  logic        busy, retire, timeout;
  logic [31:0] rcnt, scnt;
  logic [4:0]  phv;
  int          ncmp = 0;
  int          nerr = 0;

  localparam logic [4:0] PI = 5'b00000;
  localparam logic [4:0] PF = 5'b10000;
  localparam logic [4:0] PD = 5'b01000;
  localparam logic [4:0] PE = 5'b00100;
  localparam logic [4:0] PM = 5'b00010;
  localparam logic [4:0] PW = 5'b00001;

  phase_sequencer #(.STALL_LIMIT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .stall_fetch(s_f), .stall_decode(s_d),
    .stall_execute(s_e), .stall_memory(s_m),
    .stall_writeback(s_w), .cnt_clr(cnt_clr),
    .phase_fetch(p_f), .phase_decode(p_d),
    .phase_execute(p_e), .phase_memory(p_m),
    .phase_writeback(p_w), .busy(busy),
    .retire(retire), .retire_count(rcnt),
    .stall_count(scnt), .stall_timeout(timeout)
  );

  always #5 clk = ~clk;
  assign phv = {p_f, p_d, p_e, p_m, p_w};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_phv"}, 32'(phv), 32'(PI));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_retire"}, 32'(retire), 32'd0);
  endtask

  logic [4:0] seq [5];

  initial begin
    seq[0] = PF; seq[1] = PD; seq[2] = PE;
    seq[3] = PM; seq[4] = PW;
    rst_n = 1'b0; run = 1'b0; cnt_clr = 1'b0;
    s_f = 0; s_d = 0; s_e = 0; s_m = 0; s_w = 0;
    tick(); tick();
    chk_idle("reset");
    chk("reset_rcnt", rcnt, 32'd0);
    chk("reset_scnt", scnt, 32'd0);
    chk("reset_tmo", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // three back-to-back unstalled instructions
    run = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("b2b_phv%0d", i), 32'(phv), 32'(seq[i % 5]));
      chk($sformatf("b2b_ret%0d", i), 32'(retire),
          (i % 5 == 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("b2b_phv_next", 32'(phv), 32'(PF));
    chk("b2b_rcnt", rcnt, 32'd3);
    chk("b2b_scnt", scnt, 32'd0);

    // non-current stall ignored in FETCH; decode held 4 cycles
    s_m = 1'b1;
    chk("ign_phv", 32'(phv), 32'(PF));
    tick();
    s_m = 1'b0; s_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dstall_phv%0d", k), 32'(phv), 32'(PD));
      tick();
    end
    s_d = 1'b0;
    chk("dstall_phv_last", 32'(phv), 32'(PD));
    chk("dstall_scnt", scnt, 32'd4);
    chk("dstall_tmo", 32'(timeout), 32'd1);
    tick();
    chk("drop_phv_e", 32'(phv), 32'(PE));
    run = 1'b0;
    tick();
    chk("drop_phv_m", 32'(phv), 32'(PM));
    tick();
    chk("drop_phv_w", 32'(phv), 32'(PW));
    chk("drop_ret", 32'(retire), 32'd1);
    tick();
    chk_idle("drop_idle");
    chk("drop_rcnt", rcnt, 32'd4);

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr1_rcnt", rcnt, 32'd0);
    chk("clr1_scnt", scnt, 32'd0);
    chk("clr1_tmo", 32'(timeout), 32'd0);

    // watchdog: execute stalled 6 cycles with limit 4
    run = 1'b1;
    tick();
    chk("wd_phv_f", 32'(phv), 32'(PF));
    run = 1'b0;
    tick();
    tick();
    s_e = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wd_phv%0d", k), 32'(phv), 32'(PE));
      chk($sformatf("wd_tmo%0d", k), 32'(timeout),
          (k >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    s_e = 1'b0;
    chk("wd_phv_last", 32'(phv), 32'(PE));
    chk("wd_scnt", scnt, 32'd6);
    tick();
    chk("wd_phv_m", 32'(phv), 32'(PM));
    chk("wd_tmo_held", 32'(timeout), 32'd1);
    tick();
    chk("wd_phv_w", 32'(phv), 32'(PW));
    tick();
    chk_idle("wd_idle");
    chk("wd_rcnt", rcnt, 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr2_rcnt", rcnt, 32'd0);
    chk("clr2_scnt", scnt, 32'd0);
    chk("clr2_tmo", 32'(timeout), 32'd0);

    // reset in MEMORY aborts the instruction
    run = 1'b1;
    tick();
    s_f = 1'b1;
    tick();
    s_f = 1'b0;
    tick(); tick(); tick();
    chk("rst_pre_phv", 32'(phv), 32'(PM));
    chk("rst_pre_scnt", scnt, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("rst_mid");
    chk("rst_mid_scnt", scnt, 32'd0);
    chk("rst_mid_rcnt", rcnt, 32'd0);
    tick();
    chk("rst_fetch", 32'(phv), 32'(PF));

    // retire_count wrap via force, then clear vs retire
    tick(); tick(); tick();
    chk("wrap_phv_m", 32'(phv), 32'(PM));
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    chk("wrap_pre", rcnt, 32'hFFFF_FFFF);
    tick();
    chk("wrap_ret", 32'(retire), 32'd1);
    tick();
    chk("wrap_rcnt", rcnt, 32'd0);
    chk("wrap_phv_f", 32'(phv), 32'(PF));
    tick(); tick(); tick(); tick();
    chk("clrret_phv_w", 32'(phv), 32'(PW));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clrret_rcnt", rcnt, 32'd0);
    chk("clrret_phv_f", 32'(phv), 32'(PF));
    run = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk_idle("end_idle");
    chk("end_rcnt", rcnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
